mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
- Multicycle control FSM for the SCPU datapath.
- Sequences fetch, decode, execute, memory and writeback over the shared ALU, memory port, register file and the EXT16/EXT8 extenders.
- Drives the extender EXTOp and the byte-load select, and handshakes with a variable-latency memory.
- Sits between the IR opcode/funct fields and all datapath mux and enable controls.

Parameters:
- FETCH_TIMEOUT, 255, cycles without mem_ready in a memory state before mem_err pulses; 0 disables the timeout.

Ports:
- clk  in  1  rising-edge clock
- rstn  in  1  asynchronous active-low reset
- op  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completion strobe
- mem_req  out  1  memory access request; held until mem_ready
- mem_we  out  1  write qualifier for mem_req
- iord  out  1  address mux: 0=PC, 1=ALUOut
- ir_we  out  1  IR load enable
- pc_en  out  1  PC load enable (includes the branch condition)
- pc_src  out  2  0=ALU, 1=ALUOut, 2=jump target, 3=rs (jr)
- reg_we  out  1  register file write
- reg_dst  out  2  0=rt, 1=rd, 2=r31
- wd_sel  out  2  0=ALUOut, 1=MDR-word, 2=MDR-byte-ext, 3=PC
- alu_src_a  out  1  0=PC, 1=A
- alu_src_b  out  2  0=B, 1=const 4, 2=Imm32, 3=Imm32<<2
- alu_op  out  4  ALU function code
- ext_op  out  1  1=sign-extend, 0=zero-extend
- illegal  out  1  one-cycle pulse on an unknown opcode or funct
- mem_err  out  1  one-cycle pulse on a memory timeout

Behaviour:
- Reset is asynchronous with rstn=0.
  - State goes to FETCH, the timeout counter clears, and all outputs are 0.
  - While in reset, mem_req=0.
  - Reset mid-access abandons the access with no handshake completion.
- Outputs are Moore-decoded from the state plus op/funct. op/funct are stable because ir_we is asserted only in FETCH.
- States and actions:
  - FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=ADD. On mem_ready: ir_we=1, pc_en=1, pc_src=0, then go to DECODE. Otherwise stay.
  - DECODE: alu_src_a=0, alu_src_b=3, alu_op=ADD (branch target), ext_op=1. Next state by op:
    - 0x23/0x2B/0x20/0x24 -> MEMADR
    - 0x00 -> RTYPE
    - 0x04/0x05 -> BRANCH
    - 0x08/0x0C/0x0D/0x0F -> ITYPE
    - 0x02/0x03 -> JUMP
    - else -> FETCH with illegal=1
  - MEMADR: alu_src_a=1, alu_src_b=2, ext_op=1, alu_op=ADD. Next: 0x2B -> MEMWR, else MEMRD.
  - MEMRD: mem_req=1, iord=1. On mem_ready go to LOADWB.
  - MEMWR: mem_req=1, mem_we=1, iord=1. On mem_ready go to FETCH.
  - LOADWB: reg_we=1, reg_dst=0. wd_sel=1 for lw, or 2 for lb/lbu. ext_op=1 for lb, 0 for lbu (EXT8 select). Next: FETCH.
  - RTYPE:
    - funct 0x08 (jr): pc_en=1, pc_src=3, then FETCH.
    - funct 0x20/0x22/0x24/0x25/0x2A: alu_src_a=1, alu_src_b=0, alu_op from funct, then RWB.
    - Other funct: illegal=1, then FETCH.
  - RWB: reg_we=1, reg_dst=1, wd_sel=0. Next: FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=0, alu_op=SUB, pc_src=1. pc_en=zero for beq, ~zero for bne. Next: FETCH.
  - ITYPE: alu_src_a=1, alu_src_b=2. ext_op=1 for addi, 0 for andi/ori/lui. alu_op=ADD/AND/OR/LUI. Next: IWB.
  - IWB: reg_we=1, reg_dst=0, wd_sel=0. Next: FETCH.
  - JUMP: pc_en=1, pc_src=2. For jal also reg_we=1, reg_dst=2, wd_sel=3. Next: FETCH.
- Handshake:
  - mem_req rises on entry to FETCH/MEMRD/MEMWR and stays high until the cycle mem_ready=1 is sampled. It drops on exit from the state.
  - A mem_ready sampled while mem_req=0 is ignored.
  - A zero-wait-state memory (mem_ready=1 in the first cycle) completes in 1 cycle.
- Timeout:
  - An 8-bit counter increments each waiting cycle and clears on state exit.
  - When it reaches FETCH_TIMEOUT: mem_err pulses, the counter clears, and the FSM stays in state with the request held.
- Instruction cycle counts with zero-wait memory: lw/lb 5, sw 4, R-type 4, I-type 4, branch 3, jump 3, jr 3.
- ext_op is don't-care-driven-0 in states that do not use Imm32, except DECODE, MEMADR, ITYPE and LOADWB as given above.

Decomposition:
- Package mc_pkg:
  - state enum (FETCH, DECODE, MEMADR, MEMRD, MEMWR, LOADWB, RTYPE, RWB, BRANCH, ITYPE, IWB, JUMP)
  - opcode and funct constants
  - ALU_ADD/SUB/AND/OR/SLT/LUI codes
  - mux select constants
- Sub-module mc_alu_dec: combinational op/funct -> alu_op, ext_op, illegal_funct.
- The FSM and timeout counter stay in mc_ctrl.

Test Plan:
- Reset and fetch: rstn low mid-MEMRD, then high, with mem_ready tied 1 -> FETCH next cycle, mem_req=1, ir_we=1, pc_en=1, and all other outputs 0 during reset.
- lw with mem_ready delayed 3 cycles in FETCH and in MEMRD -> 11 cycles total, mem_req held steady, reg_we a single cycle with wd_sel=1.
- lb vs lbu (op 0x20/0x24) -> ext_op=1 and 0 respectively in LOADWB, with wd_sel=2 for both.
- beq with zero=1 -> pc_en=1, pc_src=1 in BRANCH; bne with zero=1 -> pc_en=0; andi -> ext_op=0 in ITYPE.
- jal -> reg_we=1, reg_dst=2, wd_sel=3, pc_src=2 in one cycle; op 0x3F -> illegal pulse in DECODE, then FETCH.
- mem_ready held 0 in FETCH with FETCH_TIMEOUT=4 -> mem_err pulses every 4 waiting cycles and mem_req stays 1.

Source files
------------

// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the SCPU multicycle controller.
// Holds the FSM state encoding, MIPS opcode/funct field values, the ALU
// function codes driven on alu_op, and the select values for every datapath
// mux the controller steers.
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWR, LOADWB,
        RTYPE, RWB, BRANCH, ITYPE, IWB, JUMP
    } state_t;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes (IR[5:0])
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // ALU function codes
    localparam logic [3:0] ALU_AND = 4'h0;
    localparam logic [3:0] ALU_OR  = 4'h1;
    localparam logic [3:0] ALU_ADD = 4'h2;
    localparam logic [3:0] ALU_SUB = 4'h6;
    localparam logic [3:0] ALU_SLT = 4'h7;
    localparam logic [3:0] ALU_LUI = 4'h8;

    // Mux selects
    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
    localparam logic [1:0] PC_SRC_RS     = 2'd3;

    localparam logic [1:0] REG_DST_RT  = 2'd0;
    localparam logic [1:0] REG_DST_RD  = 2'd1;
    localparam logic [1:0] REG_DST_R31 = 2'd2;

    localparam logic [1:0] WD_ALUOUT   = 2'd0;
    localparam logic [1:0] WD_MDR_WORD = 2'd1;
    localparam logic [1:0] WD_MDR_BYTE = 2'd2;
    localparam logic [1:0] WD_PC       = 2'd3;

    localparam logic       SRC_A_PC  = 1'b0;
    localparam logic       SRC_A_REG = 1'b1;

    localparam logic [1:0] SRC_B_REG     = 2'd0;
    localparam logic [1:0] SRC_B_FOUR    = 2'd1;
    localparam logic [1:0] SRC_B_IMM     = 2'd2;
    localparam logic [1:0] SRC_B_IMM_SH2 = 2'd3;

endpackage

// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: bundle between the multicycle controller and the SCPU datapath.
//   Datapath -> controller: op, funct (IR fields), zero (ALU flag),
//                           mem_ready (memory completion strobe).
//   Controller -> datapath: memory request/write, mux selects, enables,
//                           alu_op, ext_op, and the illegal/mem_err pulses.
// master = controller side, slave = datapath side.
interface mc_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_we;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       reg_we;
    logic [1:0] reg_dst;
    logic [1:0] wd_sel;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic       ext_op;
    logic       illegal;
    logic       mem_err;

    modport master (
        input  op, funct, zero, mem_ready,
        output mem_req, mem_we, iord, ir_we, pc_en, pc_src, reg_we, reg_dst,
               wd_sel, alu_src_a, alu_src_b, alu_op, ext_op, illegal, mem_err
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  mem_req, mem_we, iord, ir_we, pc_en, pc_src, reg_we, reg_dst,
               wd_sel, alu_src_a, alu_src_b, alu_op, ext_op, illegal, mem_err
    );
endinterface

// File: rtl/mc_alu_dec.sv
// mc_alu_dec: combinational instruction decode for the execute step.
//   op, funct     in  IR opcode / funct fields
//   alu_op        out ALU function for the RTYPE / ITYPE execute cycle
//   ext_op        out 1=sign-extend, 0=zero-extend (Imm16 for I-type, byte for lb/lbu)
//   illegal_funct out R-type with an unsupported funct
module mc_alu_dec
    import mc_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic [3:0] alu_op,
    output logic       ext_op,
    output logic       illegal_funct
);

    always_comb begin
        alu_op        = ALU_ADD;
        ext_op        = 1'b1;
        illegal_funct = 1'b0;
        if (op == OP_RTYPE) begin
            case (funct)
                FN_ADD:  alu_op = ALU_ADD;
                FN_SUB:  alu_op = ALU_SUB;
                FN_AND:  alu_op = ALU_AND;
                FN_OR:   alu_op = ALU_OR;
                FN_SLT:  alu_op = ALU_SLT;
                FN_JR:   alu_op = ALU_ADD;
                default: illegal_funct = 1'b1;
            endcase
        end else begin
            // Logical immediates and lui take a zero-extended Imm16; lbu
            // shares the same select to zero-extend the loaded byte.
            case (op)
                OP_ANDI: begin alu_op = ALU_AND; ext_op = 1'b0; end
                OP_ORI:  begin alu_op = ALU_OR;  ext_op = 1'b0; end
                OP_LUI:  begin alu_op = ALU_LUI; ext_op = 1'b0; end
                OP_LBU:  ext_op = 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle control FSM for the SCPU datapath.
//   clk   in  rising-edge clock
//   rstn  in  asynchronous active-low reset
//   bus   mc_ctrl_if.master: IR fields, zero flag, memory handshake and all
//         datapath mux/enable controls.
// Outputs are decoded from the current state plus op/funct; the handshake
// completions (FETCH ir_we/pc_en) also follow mem_ready in the same cycle so
// that a zero-wait memory finishes an access in one cycle.
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int FETCH_TIMEOUT = 255
) (
    input  logic      clk,
    input  logic      rstn,
    mc_ctrl_if.master bus
);

    // FETCH_TIMEOUT=0 turns the timeout off; otherwise mem_err fires on the
    // FETCH_TIMEOUT-th consecutive waiting cycle.
    localparam logic       TMO_EN   = (FETCH_TIMEOUT != 0);
    localparam logic [7:0] TMO_LAST = 8'(FETCH_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] tmo_q, tmo_d;
    logic       mem_wait;
    logic [3:0] dec_alu_op;
    logic       dec_ext_op;
    logic       dec_illegal_funct;

    mc_alu_dec u_alu_dec (
        .op            (bus.op),
        .funct         (bus.funct),
        .alu_op        (dec_alu_op),
        .ext_op        (dec_ext_op),
        .illegal_funct (dec_illegal_funct)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= FETCH;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
        end
    end

    // Outputs are held at 0 while rstn is low so a reset in the middle of an
    // access drops mem_req immediately rather than at the next edge.
    always_comb begin
        state_d       = state_q;
        tmo_d         = '0;
        mem_wait      = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.iord      = 1'b0;
        bus.ir_we     = 1'b0;
        bus.pc_en     = 1'b0;
        bus.pc_src    = PC_SRC_ALU;
        bus.reg_we    = 1'b0;
        bus.reg_dst   = REG_DST_RT;
        bus.wd_sel    = WD_ALUOUT;
        bus.alu_src_a = SRC_A_PC;
        bus.alu_src_b = SRC_B_REG;
        bus.alu_op    = 4'h0;
        bus.ext_op    = 1'b0;
        bus.illegal   = 1'b0;
        bus.mem_err   = 1'b0;

        if (rstn) begin
            case (state_q)
                FETCH: begin
                    bus.mem_req   = 1'b1;
                    bus.alu_src_b = SRC_B_FOUR;
                    bus.alu_op    = ALU_ADD;
                    if (bus.mem_ready) begin
                        bus.ir_we = 1'b1;
                        bus.pc_en = 1'b1;
                        state_d   = DECODE;
                    end else begin
                        mem_wait = 1'b1;
                    end
                end
                DECODE: begin
                    // Speculatively form the branch target in ALUOut.
                    bus.alu_src_b = SRC_B_IMM_SH2;
                    bus.alu_op    = ALU_ADD;
                    bus.ext_op    = 1'b1;
                    case (bus.op)
                        OP_LW, OP_SW, OP_LB, OP_LBU:      state_d = MEMADR;
                        OP_RTYPE:                         state_d = RTYPE;
                        OP_BEQ, OP_BNE:                   state_d = BRANCH;
                        OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: state_d = ITYPE;
                        OP_J, OP_JAL:                     state_d = JUMP;
                        default: begin
                            bus.illegal = 1'b1;
                            state_d     = FETCH;
                        end
                    endcase
                end
                MEMADR: begin
                    bus.alu_src_a = SRC_A_REG;
                    bus.alu_src_b = SRC_B_IMM;
                    bus.alu_op    = ALU_ADD;
                    bus.ext_op    = 1'b1;
                    state_d       = (bus.op == OP_SW) ? MEMWR : MEMRD;
                end
                MEMRD: begin
                    bus.mem_req = 1'b1;
                    bus.iord    = 1'b1;
                    if (bus.mem_ready) state_d = LOADWB;
                    else               mem_wait = 1'b1;
                end
                MEMWR: begin
                    bus.mem_req = 1'b1;
                    bus.mem_we  = 1'b1;
                    bus.iord    = 1'b1;
                    if (bus.mem_ready) state_d = FETCH;
                    else               mem_wait = 1'b1;
                end
                LOADWB: begin
                    bus.reg_we = 1'b1;
                    bus.wd_sel = (bus.op == OP_LW) ? WD_MDR_WORD : WD_MDR_BYTE;
                    bus.ext_op = dec_ext_op;
                    state_d    = FETCH;
                end
                RTYPE: begin
                    state_d = FETCH;
                    if (bus.funct == FN_JR) begin
                        bus.pc_en  = 1'b1;
                        bus.pc_src = PC_SRC_RS;
                    end else if (dec_illegal_funct) begin
                        bus.illegal = 1'b1;
                    end else begin
                        bus.alu_src_a = SRC_A_REG;
                        bus.alu_src_b = SRC_B_REG;
                        bus.alu_op    = dec_alu_op;
                        state_d       = RWB;
                    end
                end
                RWB: begin
                    bus.reg_we  = 1'b1;
                    bus.reg_dst = REG_DST_RD;
                    state_d     = FETCH;
                end
                BRANCH: begin
                    bus.alu_src_a = SRC_A_REG;
                    bus.alu_op    = ALU_SUB;
                    bus.pc_src    = PC_SRC_ALUOUT;
                    bus.pc_en     = (bus.op == OP_BEQ) ? bus.zero : ~bus.zero;
                    state_d       = FETCH;
                end
                ITYPE: begin
                    bus.alu_src_a = SRC_A_REG;
                    bus.alu_src_b = SRC_B_IMM;
                    bus.alu_op    = dec_alu_op;
                    bus.ext_op    = dec_ext_op;
                    state_d       = IWB;
                end
                IWB: begin
                    bus.reg_we = 1'b1;
                    state_d    = FETCH;
                end
                JUMP: begin
                    bus.pc_en  = 1'b1;
                    bus.pc_src = PC_SRC_JUMP;
                    if (bus.op == OP_JAL) begin
                        bus.reg_we  = 1'b1;
                        bus.reg_dst = REG_DST_R31;
                        bus.wd_sel  = WD_PC;
                    end
                    state_d = FETCH;
                end
                default: state_d = FETCH;
            endcase

            // Waiting cycles are counted; on expiry the request stays up and
            // the count restarts so mem_err repeats every FETCH_TIMEOUT cycles.
            if (mem_wait) begin
                if (TMO_EN && (tmo_q == TMO_LAST)) begin
                    bus.mem_err = 1'b1;
                    tmo_d       = '0;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: self-checking bench for mc_ctrl.
// A table of instructions is run back to back with a zero-wait memory; for
// each one the expected length and the expected control word in one chosen
// cycle go into a scoreboard queue and are popped when the next fetch shows
// the instruction has finished. Hand-written sequences cover a slow memory,
// the fetch timeout and reset in the middle of a load.
module tb_mc_ctrl;
    import mc_pkg::*;

    localparam int TO = 4;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_we;
        logic       pc_en;
        logic [1:0] pc_src;
        logic       reg_we;
        logic [1:0] reg_dst;
        logic [1:0] wd_sel;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
        logic       ext_op;
        logic       illegal;
        logic       mem_err;
    } ctl_t;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        int         cycles;
        int         chk;
        ctl_t       exp;
    } vec_t;

    typedef struct {
        string name;
        int    cycles;
        ctl_t  exp;
    } exp_t;

    logic clk;
    logic rstn;
    int   n_vec;
    int   n_err;
    vec_t vecs[$];
    exp_t sb[$];

    mc_ctrl_if bus ();

    mc_ctrl #(.FETCH_TIMEOUT(TO)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ctl_t sample();
        ctl_t c;
        c.mem_req   = bus.mem_req;
        c.mem_we    = bus.mem_we;
        c.iord      = bus.iord;
        c.ir_we     = bus.ir_we;
        c.pc_en     = bus.pc_en;
        c.pc_src    = bus.pc_src;
        c.reg_we    = bus.reg_we;
        c.reg_dst   = bus.reg_dst;
        c.wd_sel    = bus.wd_sel;
        c.alu_src_a = bus.alu_src_a;
        c.alu_src_b = bus.alu_src_b;
        c.alu_op    = bus.alu_op;
        c.ext_op    = bus.ext_op;
        c.illegal   = bus.illegal;
        c.mem_err   = bus.mem_err;
        return c;
    endfunction

    function automatic vec_t mkv(string n, logic [5:0] op, logic [5:0] fn,
                                 logic z, int cyc, int chk, ctl_t e);
        vec_t v;
        v.name = n; v.op = op; v.funct = fn; v.zero = z;
        v.cycles = cyc; v.chk = chk; v.exp = e;
        return v;
    endfunction

    task automatic compare(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Pops the oldest outstanding instruction and compares what was observed.
    task automatic checkOutput(input int obs_cycles, input ctl_t obs);
        exp_t e;
        if (sb.size() == 0) begin
            compare("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            compare({e.name, "_cycles"}, 32'(obs_cycles), 32'(e.cycles));
            compare({e.name, "_ctl"}, 32'(obs), 32'(e.exp));
        end
    endtask

    // Entered #1 after the negedge of a fetch cycle with ir_we=1; the IR
    // loads at the following posedge, so op/funct change here. Returns at the
    // same point of the next fetch.
    task automatic applyStimulus(input vec_t v);
        exp_t e;
        ctl_t cap;
        int   cyc;
        logic done;
        cap = '0;
        if (v.chk == 1) cap = sample();
        bus.op    = v.op;
        bus.funct = v.funct;
        bus.zero  = v.zero;
        e.name = v.name; e.cycles = v.cycles; e.exp = v.exp;
        sb.push_back(e);
        cyc  = 1;
        done = 1'b0;
        while (!done && cyc < 20) begin
            @(negedge clk);
            #1;
            if (bus.ir_we) begin
                done = 1'b1;
            end else begin
                cyc++;
                if (cyc == v.chk) cap = sample();
            end
        end
        checkOutput(cyc, cap);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        ctl_t        fetch_ctl, decode_ctl;
        logic [11:1] req_obs, rwe_obs, irwe_obs, iord_obs;
        logic [1:0]  wd_obs;
        logic [12:1] err_obs, err_exp, req12;

        n_vec = 0;
        n_err = 0;
        fetch_ctl  = '{mem_req:1'b1, ir_we:1'b1, pc_en:1'b1, alu_src_b:2'd1, alu_op:ALU_ADD, default:'0};
        decode_ctl = '{alu_src_b:2'd3, alu_op:ALU_ADD, ext_op:1'b1, default:'0};

        vecs.push_back(mkv("lw_fetch",  OP_LW, 6'h00, 1'b0, 5, 1, fetch_ctl));
        vecs.push_back(mkv("lw_decode", OP_LW, 6'h00, 1'b0, 5, 2, decode_ctl));
        vecs.push_back(mkv("lw_memadr", OP_LW, 6'h00, 1'b0, 5, 3,
            '{alu_src_a:1'b1, alu_src_b:2'd2, alu_op:ALU_ADD, ext_op:1'b1, default:'0}));
        vecs.push_back(mkv("lw_memrd",  OP_LW, 6'h00, 1'b0, 5, 4, '{mem_req:1'b1, iord:1'b1, default:'0}));
        vecs.push_back(mkv("lw_wb",     OP_LW, 6'h00, 1'b0, 5, 5,
            '{reg_we:1'b1, wd_sel:2'd1, ext_op:1'b1, default:'0}));
        vecs.push_back(mkv("lb_wb",     OP_LB, 6'h00, 1'b0, 5, 5,
            '{reg_we:1'b1, wd_sel:2'd2, ext_op:1'b1, default:'0}));
        vecs.push_back(mkv("lbu_wb",    OP_LBU, 6'h00, 1'b0, 5, 5, '{reg_we:1'b1, wd_sel:2'd2, default:'0}));
        vecs.push_back(mkv("sw_memwr",  OP_SW, 6'h00, 1'b0, 4, 4,
            '{mem_req:1'b1, mem_we:1'b1, iord:1'b1, default:'0}));
        vecs.push_back(mkv("add_ex", OP_RTYPE, FN_ADD, 1'b0, 4, 3, '{alu_src_a:1'b1, alu_op:ALU_ADD, default:'0}));
        vecs.push_back(mkv("sub_ex", OP_RTYPE, FN_SUB, 1'b0, 4, 3, '{alu_src_a:1'b1, alu_op:ALU_SUB, default:'0}));
        vecs.push_back(mkv("and_ex", OP_RTYPE, FN_AND, 1'b0, 4, 3, '{alu_src_a:1'b1, alu_op:ALU_AND, default:'0}));
        vecs.push_back(mkv("or_ex",  OP_RTYPE, FN_OR,  1'b0, 4, 3, '{alu_src_a:1'b1, alu_op:ALU_OR,  default:'0}));
        vecs.push_back(mkv("slt_ex", OP_RTYPE, FN_SLT, 1'b0, 4, 3, '{alu_src_a:1'b1, alu_op:ALU_SLT, default:'0}));
        vecs.push_back(mkv("add_wb", OP_RTYPE, FN_ADD, 1'b0, 4, 4, '{reg_we:1'b1, reg_dst:2'd1, default:'0}));
        vecs.push_back(mkv("beq_taken", OP_BEQ, 6'h00, 1'b1, 3, 3,
            '{pc_en:1'b1, pc_src:2'd1, alu_src_a:1'b1, alu_op:ALU_SUB, default:'0}));
        vecs.push_back(mkv("bne_z1", OP_BNE, 6'h00, 1'b1, 3, 3,
            '{pc_src:2'd1, alu_src_a:1'b1, alu_op:ALU_SUB, default:'0}));
        vecs.push_back(mkv("beq_z0", OP_BEQ, 6'h00, 1'b0, 3, 3,
            '{pc_src:2'd1, alu_src_a:1'b1, alu_op:ALU_SUB, default:'0}));
        vecs.push_back(mkv("bne_z0", OP_BNE, 6'h00, 1'b0, 3, 3,
            '{pc_en:1'b1, pc_src:2'd1, alu_src_a:1'b1, alu_op:ALU_SUB, default:'0}));
        vecs.push_back(mkv("addi_ex", OP_ADDI, 6'h00, 1'b0, 4, 3,
            '{alu_src_a:1'b1, alu_src_b:2'd2, alu_op:ALU_ADD, ext_op:1'b1, default:'0}));
        vecs.push_back(mkv("andi_ex", OP_ANDI, 6'h00, 1'b0, 4, 3,
            '{alu_src_a:1'b1, alu_src_b:2'd2, alu_op:ALU_AND, default:'0}));
        vecs.push_back(mkv("ori_ex", OP_ORI, 6'h00, 1'b0, 4, 3,
            '{alu_src_a:1'b1, alu_src_b:2'd2, alu_op:ALU_OR, default:'0}));
        vecs.push_back(mkv("lui_ex", OP_LUI, 6'h00, 1'b0, 4, 3,
            '{alu_src_a:1'b1, alu_src_b:2'd2, alu_op:ALU_LUI, default:'0}));
        vecs.push_back(mkv("addi_wb", OP_ADDI, 6'h00, 1'b0, 4, 4, '{reg_we:1'b1, default:'0}));
        vecs.push_back(mkv("jal", OP_JAL, 6'h00, 1'b0, 3, 3,
            '{pc_en:1'b1, pc_src:2'd2, reg_we:1'b1, reg_dst:2'd2, wd_sel:2'd3, default:'0}));
        vecs.push_back(mkv("j", OP_J, 6'h00, 1'b0, 3, 3, '{pc_en:1'b1, pc_src:2'd2, default:'0}));
        vecs.push_back(mkv("jr", OP_RTYPE, FN_JR, 1'b0, 3, 3, '{pc_en:1'b1, pc_src:2'd3, default:'0}));
        vecs.push_back(mkv("bad_op", 6'h3F, 6'h00, 1'b0, 2, 2,
            '{alu_src_b:2'd3, alu_op:ALU_ADD, ext_op:1'b1, illegal:1'b1, default:'0}));
        vecs.push_back(mkv("bad_funct", OP_RTYPE, 6'h3F, 1'b0, 3, 3, '{illegal:1'b1, default:'0}));

        // Reset: everything low, including mem_req with mem_ready high.
        rstn          = 1'b0;
        bus.mem_ready = 1'b1;
        bus.op        = 6'h00;
        bus.funct     = 6'h00;
        bus.zero      = 1'b0;
        #3;
        compare("reset_outputs", 32'(sample()), 32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        #1;
        compare("first_fetch", 32'(sample()), 32'(fetch_ctl));

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Run a j, then a lw with 3 wait cycles in both FETCH and MEMRD.
        bus.op    = OP_J;
        bus.funct = 6'h00;
        @(negedge clk);
        @(negedge clk);
        bus.mem_ready = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            bus.mem_ready = (c == 4) || (c == 10);
            #1;
            req_obs[c]  = bus.mem_req;
            rwe_obs[c]  = bus.reg_we;
            irwe_obs[c] = bus.ir_we;
            iord_obs[c] = bus.iord;
            if (c == 11) wd_obs = bus.wd_sel;
            if (c == 4)  bus.op = OP_LW;
        end
        bus.mem_ready = 1'b0;
        compare("slow_lw_mem_req", 32'(req_obs),  32'(11'b01111001111));
        compare("slow_lw_reg_we",  32'(rwe_obs),  32'(11'b10000000000));
        compare("slow_lw_ir_we",   32'(irwe_obs), 32'(11'b00000001000));
        compare("slow_lw_iord",    32'(iord_obs), 32'(11'b01111000000));
        compare("slow_lw_wd_sel",  32'(wd_obs),   32'd1);

        // Next fetch never sees mem_ready: mem_err every TO waiting cycles.
        for (int w = 1; w <= 12; w++) begin
            @(negedge clk);
            #1;
            err_obs[w] = bus.mem_err;
            req12[w]   = bus.mem_req;
            err_exp[w] = ((w % TO) == 0);
        end
        compare("timeout_mem_err", 32'(err_obs), 32'(err_exp));
        compare("timeout_mem_req", 32'(req12), 32'hFFF);

        // Complete the fetch as a lw, then reset while MEMRD is waiting.
        bus.op = OP_LW;
        @(negedge clk);
        bus.mem_ready = 1'b1;
        #1;
        compare("late_fetch_ir_we", 32'(bus.ir_we), 32'd1);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        bus.mem_ready = 1'b0;
        #1;
        compare("memrd_before_reset", 32'(sample()), 32'({1'b1, 1'b0, 1'b1, 19'd0}));
        #2;
        rstn = 1'b0;
        #1;
        compare("reset_mid_memrd", 32'(sample()), 32'd0);
        bus.mem_ready = 1'b1;
        #1;
        compare("reset_req_low", 32'(bus.mem_req), 32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        #1;
        compare("fetch_after_reset", 32'(sample()), 32'(fetch_ctl));
        @(negedge clk);
        #1;
        compare("decode_after_reset", 32'(sample()), 32'(decode_ctl));

        compare("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
